// File: rtl/mem_write_checker.sv
// ---------------------------------------------------------------------------
// mem_write_checker : snoops the core data-memory write port against a table of
// expected stores and reports pass / fail / timeout on registered outputs. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mem_write_checker #(
  parameter int                          ADDR_W      = 32,
  parameter int                          DATA_W      = 32,
  parameter int                          NUM_EXP     = 1,
  parameter logic [NUM_EXP*ADDR_W-1:0]   EXP_ADDR    = {32'd100},
  parameter logic [NUM_EXP*DATA_W-1:0]   EXP_DATA    = {32'd25},
  parameter bit                          ORDERED     = 1'b1,
  parameter bit                          IGNORE_EN   = 1'b1,
  parameter logic [ADDR_W-1:0]           IGNORE_ADDR = 96,
  parameter int                          TIMEOUT     = 1000,
  localparam int                         MC_W        = $clog2(NUM_EXP + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] data_adr,
  input  logic [DATA_W-1:0] write_data,
  output logic              done,
  output logic              pass,
  output logic              fail,
  output logic [2:0]        fail_code,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_data,
  output logic [MC_W-1:0]   match_count,
  output logic [31:0]       cycle_count
);

  localparam logic [1:0] S_RUN  = 2'd0;
  localparam logic [1:0] S_PASS = 2'd1;
  localparam logic [1:0] S_FAIL = 2'd2;

  localparam logic [2:0] FC_NONE    = 3'd0;
  localparam logic [2:0] FC_ADDR    = 3'd1;
  localparam logic [2:0] FC_DATA    = 3'd2;
  localparam logic [2:0] FC_TIMEOUT = 3'd3;
  localparam logic [2:0] FC_DUP     = 3'd4;

  logic [1:0]         state_q, state_d;
  logic [MC_W-1:0]    match_count_q, match_count_d;
  logic [NUM_EXP-1:0] hit_q, hit_d;
  logic [2:0]         fail_code_q, fail_code_d;
  logic [ADDR_W-1:0]  fail_addr_q, fail_addr_d;
  logic [DATA_W-1:0]  fail_data_q, fail_data_d;
  logic [31:0]        cycle_count_q, cycle_count_d;

  logic               w_ign, w_found, w_uaddr, w_haddr, w_take, w_last, w_tmo;
  logic [NUM_EXP-1:0] w_set;
  logic [ADDR_W-1:0]  w_exp_a;
  logic [DATA_W-1:0]  w_exp_d;
  logic [2:0]         w_code;

  always_comb begin
    w_ign = IGNORE_EN && (data_adr == IGNORE_ADDR);

    // In ordered mode the match count doubles as the index of the next entry.
    w_exp_a = '0;
    w_exp_d = '0;
    for (int i = 0; i < NUM_EXP; i++) begin
      if (match_count_q == MC_W'(i)) begin
        w_exp_a = EXP_ADDR[i*ADDR_W +: ADDR_W];
        w_exp_d = EXP_DATA[i*DATA_W +: DATA_W];
      end
    end

    w_found = 1'b0;
    w_set   = '0;
    w_uaddr = 1'b0;
    w_haddr = 1'b0;
    for (int i = 0; i < NUM_EXP; i++) begin
      if (data_adr == EXP_ADDR[i*ADDR_W +: ADDR_W]) begin
        if (hit_q[i]) begin
          w_haddr = 1'b1;
        end else begin
          w_uaddr = 1'b1;
          if (!w_found && (write_data == EXP_DATA[i*DATA_W +: DATA_W])) begin
            w_found  = 1'b1;
            w_set[i] = 1'b1;
          end
        end
      end
    end

    w_take = 1'b0;
    w_code = FC_NONE;
    if (mem_write && !w_ign) begin
      if (ORDERED) begin
        if (data_adr == w_exp_a) begin
          if (write_data == w_exp_d) w_take = 1'b1;
          else                       w_code = FC_DATA;
        end else begin
          w_code = FC_ADDR;
        end
      end else begin
        if (w_found)      w_take = 1'b1;
        else if (w_uaddr) w_code = FC_DATA;
        else if (w_haddr) w_code = FC_DUP;
        else              w_code = FC_ADDR;
      end
    end

    w_last = (match_count_q == MC_W'(NUM_EXP - 1));
    w_tmo  = (TIMEOUT != 0) && (cycle_count_q == 32'(TIMEOUT - 1));

    state_d       = state_q;
    match_count_d = match_count_q;
    hit_d         = hit_q;
    fail_code_d   = fail_code_q;
    fail_addr_d   = fail_addr_q;
    fail_data_d   = fail_data_q;
    cycle_count_d = cycle_count_q;

    if (state_q == S_RUN) begin
      if (cycle_count_q != '1) cycle_count_d = cycle_count_q + 32'd1;
      if (w_take) begin
        match_count_d = match_count_q + MC_W'(1);
        hit_d         = hit_q | w_set;
      end
      // A completing match beats a timeout on the same edge.
      if (w_take && w_last) begin
        state_d = S_PASS;
      end else if (w_tmo) begin
        state_d     = S_FAIL;
        fail_code_d = FC_TIMEOUT;
        fail_addr_d = '0;
        fail_data_d = '0;
      end else if (w_code != FC_NONE) begin
        state_d     = S_FAIL;
        fail_code_d = w_code;
        fail_addr_d = data_adr;
        fail_data_d = write_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= S_RUN;
      match_count_q <= '0;
      hit_q         <= '0;
      fail_code_q   <= FC_NONE;
      fail_addr_q   <= '0;
      fail_data_q   <= '0;
      cycle_count_q <= '0;
    end else begin
      state_q       <= state_d;
      match_count_q <= match_count_d;
      hit_q         <= hit_d;
      fail_code_q   <= fail_code_d;
      fail_addr_q   <= fail_addr_d;
      fail_data_q   <= fail_data_d;
      cycle_count_q <= cycle_count_d;
    end
  end

  assign pass        = (state_q == S_PASS);
  assign fail        = (state_q == S_FAIL);
  assign done        = pass | fail;
  assign fail_code   = fail_code_q;
  assign fail_addr   = fail_addr_q;
  assign fail_data   = fail_data_q;
  assign match_count = match_count_q;
  assign cycle_count = cycle_count_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_write_checker.sv
// ---------------------------------------------------------------------------
// tb_mem_write_checker : four checker configurations driven by shared directed
// and random stimulus, each compared with a table-based reference model. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mem_write_checker;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_write;
  logic [31:0] data_adr;
  logic [31:0] write_data;

  logic        done_w [4];
  logic        pass_w [4];
  logic        fail_w [4];
  logic [2:0]  code_w [4];
  logic [31:0] fa_w   [4];
  logic [31:0] fd_w   [4];
  logic [31:0] cyc_w  [4];
  logic [0:0]  mc0, mc1;
  logic [1:0]  mc2, mc3;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_write_checker u0 (
    .clk(clk), .reset(reset), .mem_write(mem_write), .data_adr(data_adr), .write_data(write_data),
    .done(done_w[0]), .pass(pass_w[0]), .fail(fail_w[0]), .fail_code(code_w[0]),
    .fail_addr(fa_w[0]), .fail_data(fd_w[0]), .match_count(mc0), .cycle_count(cyc_w[0]));

  mem_write_checker #(.TIMEOUT(20)) u1 (
    .clk(clk), .reset(reset), .mem_write(mem_write), .data_adr(data_adr), .write_data(write_data),
    .done(done_w[1]), .pass(pass_w[1]), .fail(fail_w[1]), .fail_code(code_w[1]),
    .fail_addr(fa_w[1]), .fail_data(fd_w[1]), .match_count(mc1), .cycle_count(cyc_w[1]));

  mem_write_checker #(.NUM_EXP(2), .ORDERED(1'b0),
                      .EXP_ADDR({32'd104, 32'd100}), .EXP_DATA({32'd7, 32'd25})) u2 (
    .clk(clk), .reset(reset), .mem_write(mem_write), .data_adr(data_adr), .write_data(write_data),
    .done(done_w[2]), .pass(pass_w[2]), .fail(fail_w[2]), .fail_code(code_w[2]),
    .fail_addr(fa_w[2]), .fail_data(fd_w[2]), .match_count(mc2), .cycle_count(cyc_w[2]));

  mem_write_checker #(.NUM_EXP(2), .ORDERED(1'b1),
                      .EXP_ADDR({32'd104, 32'd100}), .EXP_DATA({32'd7, 32'd25})) u3 (
    .clk(clk), .reset(reset), .mem_write(mem_write), .data_adr(data_adr), .write_data(write_data),
    .done(done_w[3]), .pass(pass_w[3]), .fail(fail_w[3]), .fail_code(code_w[3]),
    .fail_addr(fa_w[3]), .fail_data(fd_w[3]), .match_count(mc3), .cycle_count(cyc_w[3]));

  // Per-instance configuration and the shared expected table.
  int          c_n   [4] = '{1, 1, 2, 2};
  bit          c_ord [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
  int          c_to  [4] = '{1000, 20, 1000, 1000};
  logic [31:0] c_a   [2] = '{32'd100, 32'd104};
  logic [31:0] c_d   [2] = '{32'd25, 32'd7};

  // Model state: 0 running, 1 passed, 2 failed.
  int          m_st   [4];
  int          m_mc   [4];
  int          m_code [4];
  logic [31:0] m_cyc  [4];
  logic [31:0] m_fa   [4];
  logic [31:0] m_fd   [4];
  bit          m_used [4][2];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] get_mc(input int k);
    case (k)
      0:       return {31'd0, mc0};
      1:       return {31'd0, mc1};
      2:       return {30'd0, mc2};
      default: return {30'd0, mc3};
    endcase
  endfunction

  task automatic model_step(input int k);
    int hit_j;
    int code;
    int nxt;
    bit any_unused_a;
    bit any_used_a;
    if (!reset) begin
      m_st[k] = 0; m_mc[k] = 0; m_code[k] = 0;
      m_cyc[k] = 0; m_fa[k] = 0; m_fd[k] = 0;
      m_used[k][0] = 0; m_used[k][1] = 0;
      return;
    end
    if (m_st[k] != 0) return;
    hit_j = -1; code = 0; any_unused_a = 0; any_used_a = 0;
    if (mem_write && data_adr != 32'd96) begin
      if (c_ord[k]) begin
        nxt = m_mc[k];
        if (data_adr == c_a[nxt]) begin
          if (write_data == c_d[nxt]) hit_j = nxt;
          else code = 2;
        end else code = 1;
      end else begin
        for (int j = 0; j < c_n[k]; j++)
          if (hit_j < 0 && !m_used[k][j] && data_adr == c_a[j] && write_data == c_d[j]) hit_j = j;
        if (hit_j < 0) begin
          for (int j = 0; j < c_n[k]; j++)
            if (data_adr == c_a[j]) begin
              if (m_used[k][j]) any_used_a = 1;
              else any_unused_a = 1;
            end
          code = any_unused_a ? 2 : (any_used_a ? 4 : 1);
        end
      end
    end
    if (hit_j >= 0) begin
      m_used[k][hit_j] = 1;
      m_mc[k]++;
    end
    if (m_mc[k] == c_n[k]) m_st[k] = 1;
    else if (c_to[k] != 0 && m_cyc[k] == 32'(c_to[k] - 1)) begin
      m_st[k] = 2; m_code[k] = 3; m_fa[k] = 0; m_fd[k] = 0;
    end else if (code != 0) begin
      m_st[k] = 2; m_code[k] = code; m_fa[k] = data_adr; m_fd[k] = write_data;
    end
    if (m_cyc[k] != 32'hFFFF_FFFF) m_cyc[k]++;
  endtask

  task automatic check_all(input int k);
    check($sformatf("u%0d.done", k),  {31'd0, done_w[k]}, {31'd0, m_st[k] != 0});
    check($sformatf("u%0d.pass", k),  {31'd0, pass_w[k]}, {31'd0, m_st[k] == 1});
    check($sformatf("u%0d.fail", k),  {31'd0, fail_w[k]}, {31'd0, m_st[k] == 2});
    check($sformatf("u%0d.code", k),  {29'd0, code_w[k]}, 32'(m_code[k]));
    check($sformatf("u%0d.faddr", k), fa_w[k], m_fa[k]);
    check($sformatf("u%0d.fdata", k), fd_w[k], m_fd[k]);
    check($sformatf("u%0d.mcount", k), get_mc(k), 32'(m_mc[k]));
    check($sformatf("u%0d.cycles", k), cyc_w[k], m_cyc[k]);
  endtask

  task automatic do_cycle(input bit rst_n, input bit we, input logic [31:0] a, input logic [31:0] d);
    reset = rst_n; mem_write = we; data_adr = a; write_data = d;
    @(posedge clk);
    for (int k = 0; k < 4; k++) model_step(k);
    @(negedge clk);
    for (int k = 0; k < 4; k++) check_all(k);
  endtask

  function automatic logic [31:0] pick_addr();
    case ($urandom_range(0, 4))
      0:       return 32'd96;
      1:       return 32'd100;
      2:       return 32'd104;
      3:       return 32'd108;
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [31:0] pick_data();
    case ($urandom_range(0, 3))
      0:       return 32'd25;
      1:       return 32'd7;
      2:       return 32'd24;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    // Writes during reset are discarded.
    for (int i = 0; i < 3; i++) do_cycle(1'b0, 1'b1, 32'd100, 32'd25);
    check("rst.mcount", get_mc(0), 32'd0);
    check("rst.done", {31'd0, done_w[0]}, 32'd0);

    // Ignored address then the expected store.
    do_cycle(1'b1, 1'b1, 32'd96, 32'd7);
    do_cycle(1'b1, 1'b1, 32'd100, 32'd25);
    check("pass.pass", {31'd0, pass_w[0]}, 32'd1);
    check("pass.mcount", get_mc(0), 32'd1);
    check("pass.code", {29'd0, code_w[0]}, 32'd0);

    // Unexpected address, then sticky FAIL.
    do_cycle(1'b0, 1'b0, 32'd0, 32'd0);
    do_cycle(1'b1, 1'b1, 32'd104, 32'd25);
    check("badaddr.code", {29'd0, code_w[0]}, 32'd1);
    check("badaddr.faddr", fa_w[0], 32'd104);
    do_cycle(1'b1, 1'b1, 32'd100, 32'd25);
    check("sticky.fdata", fd_w[0], 32'd25);
    check("sticky.pass", {31'd0, pass_w[0]}, 32'd0);

    // Data mismatch.
    do_cycle(1'b0, 1'b0, 32'd0, 32'd0);
    do_cycle(1'b1, 1'b1, 32'd100, 32'd24);
    check("baddata.code", {29'd0, code_w[0]}, 32'd2);
    check("baddata.fdata", fd_w[0], 32'd24);

    // Timeout on the 20th RUN edge, then a restart.
    do_cycle(1'b0, 1'b0, 32'd0, 32'd0);
    for (int i = 0; i < 19; i++) do_cycle(1'b1, 1'b0, 32'd0, 32'd0);
    check("tmo.early", {31'd0, fail_w[1]}, 32'd0);
    do_cycle(1'b1, 1'b0, 32'd0, 32'd0);
    check("tmo.code", {29'd0, code_w[1]}, 32'd3);
    check("tmo.cycles", cyc_w[1], 32'd20);
    for (int i = 0; i < 3; i++) do_cycle(1'b1, 1'b0, 32'd0, 32'd0);
    check("tmo.frozen", cyc_w[1], 32'd20);
    do_cycle(1'b0, 1'b0, 32'd0, 32'd0);
    check("tmo.rstcnt", cyc_w[1], 32'd0);
    do_cycle(1'b1, 1'b0, 32'd0, 32'd0);
    check("tmo.restart", cyc_w[1], 32'd1);

    // Out-of-order completion and early-address failure in ordered mode.
    do_cycle(1'b0, 1'b0, 32'd0, 32'd0);
    do_cycle(1'b1, 1'b1, 32'd104, 32'd7);
    check("ord.early", {29'd0, code_w[3]}, 32'd1);
    do_cycle(1'b1, 1'b1, 32'd100, 32'd25);
    check("unord.pass", {31'd0, pass_w[2]}, 32'd1);
    check("unord.mcount", get_mc(2), 32'd2);

    // Duplicate write.
    do_cycle(1'b0, 1'b0, 32'd0, 32'd0);
    do_cycle(1'b1, 1'b1, 32'd104, 32'd7);
    do_cycle(1'b1, 1'b1, 32'd104, 32'd7);
    check("dup.code", {29'd0, code_w[2]}, 32'd4);

    // Random episodes with occasional mid-run resets.
    for (int ep = 0; ep < 12; ep++) begin
      do_cycle(1'b0, 1'b0, 32'd0, 32'd0);
      for (int c = 0; c < 30; c++)
        do_cycle($urandom_range(0, 39) != 0, 1'($urandom_range(0, 1)), pick_addr(), pick_data());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_write_checker.md
# mem_write_checker

Synthesizable, parametrised self-checking monitor for the RISC-V core's data-memory write port. It sits beside `top`, snoops `MemWrite`/`DataAdr`/`WriteData` every cycle, and compares them against a table of expected stores. The table can hold any number of entries and can be matched in order or in any order. The checker reports pass, fail (with cause, address and data) or timeout through registered status outputs. Benches and FPGA bring-up both use these outputs in place of ad-hoc `$display`/`$stop` checks.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `NUM_EXP`, 1, number of expected writes (≥1)
- `EXP_ADDR`, {32'd100}, packed `NUM_EXP*ADDR_W`; entry i at bits [i*ADDR_W +: ADDR_W]
- `EXP_DATA`, {32'd25}, packed `NUM_EXP*DATA_W`, same layout
- `ORDERED`, 1, 1 = entries must match in index order; 0 = any order
- `IGNORE_EN`, 1, enables the don't-care address
- `IGNORE_ADDR`, 96, writes to this address are silently ignored
- `TIMEOUT`, 1000, cycles allowed in RUN before failing; 0 disables
- `clk` in 1 system clock, rising edge
- `reset` in 1 synchronous, active-low reset
- `mem_write` in 1 core `MemWrite`
- `data_adr` in ADDR_W core `DataAdr`
- `write_data` in DATA_W core `WriteData`
- `done` out 1 checker reached PASS or FAIL
- `pass` out 1 all expected writes seen
- `fail` out 1 check failed
- `fail_code` out 3 0 none, 1 unexpected address, 2 data mismatch, 3 timeout, 4 duplicate write
- `fail_addr` out ADDR_W address of the offending write (0 for timeout)
- `fail_data` out DATA_W data of the offending write (0 for timeout)
- `match_count` out $clog2(NUM_EXP+1) expected writes matched so far
- `cycle_count` out 32 cycles spent in RUN, saturating at all-ones

## Operation
- States: RUN, PASS, FAIL. `reset`=0 at a rising edge forces RUN and clears all outputs, the index and the hit mask to 0.
- In RUN, each edge with `mem_write`=1 is classified in this priority order:
  - ignore: `IGNORE_EN` and `data_adr`==`IGNORE_ADDR` → no state change. Ignore takes precedence even if the address is also in the table.
  - ordered: address equals `EXP_ADDR[idx]`. Data equal → idx++, `match_count`++. Data unequal → FAIL, code 2.
  - unordered: find the lowest unhit entry i whose address matches. If its data matches → set hit[i], `match_count`++. If no unhit entry matches the address but a hit entry does → FAIL, code 4.
  - an address-matched entry with wrong data (unordered, no data match among unhit entries) → FAIL, code 2.
  - otherwise → FAIL, code 1. In ordered mode this includes a later table address arriving early.
- After the match that brings `match_count` to `NUM_EXP` → PASS.
- Timeout: `TIMEOUT`≠0 and `cycle_count`==`TIMEOUT`-1 on an edge in RUN with no completing match → FAIL, code 3.
- PASS and FAIL are sticky until reset. Core activity is ignored in both states. `fail_*` are captured once and never overwritten.
- `pass`=1 iff state is PASS. `fail`=1 iff state is FAIL. `done` = `pass`|`fail`.

## Timing
- All outputs are registered. A write sampled at edge N is reflected on the outputs after edge N (visible at the following negedge).
- `cycle_count` increments on every edge in RUN, starting with the first edge where `reset`=1. It freezes on entering PASS or FAIL.
- Simultaneous events: a completing match on the timeout edge → PASS, no timeout. A write on an edge with `reset`=0 is discarded.
- Reset mid-operation (any state) → RUN with everything cleared on that edge. `mem_write` sampled on the reset edge has no effect.
- No combinational path from inputs to outputs.

## Test plan
- Default params. Hold `reset`=0 for 3 edges while driving write (100,25) → all outputs stay 0 and `match_count`=0.
- Default params. Write (96,7), then write (100,25) → after the second write, `pass`=`done`=1, `match_count`=1, `fail_code`=0.
- Default params. Write (104,25) → `fail`=1, `fail_code`=1, `fail_addr`=104, `fail_data`=25. A later write (100,25) leaves the outputs unchanged.
- Default params. Write (100,24) → `fail_code`=2, `fail_addr`=100, `fail_data`=24.
- `TIMEOUT`=20, no writes → `fail` rises after the 20th RUN edge with `fail_code`=3 and `cycle_count`=20. Reset mid-run then restarts the count from 0.
- `NUM_EXP`=2, `ORDERED`=0, table (100,25),(104,7):
  - write 104/7 then 100/25 → PASS, `match_count`=2.
  - after a fresh reset, write 104/7 twice → `fail_code`=4.
  - with `ORDERED`=1, write 104/7 first → `fail_code`=1.
